prog_load_ctrl: RTL

Sequencer that brings up the pipelined CPU core from a byte-serial host link.
- Program load: assembles framed program bytes into 32-bit words and writes them into instruction memory, holding the CPU in reset meanwhile.
- Run: releases the CPU for a fixed number of cycles.
- Dump: walks the CPU's register/data readout port (DataOrReg, address, vout_addr, value_o) and streams result bytes out over a valid/ready handshake.
- Sits between the host/bench and the CPU top-level.

---
 rtl/prog_load_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/prog_load_ctrl.sv
// Host-link loader and run/dump sequencer for the pipelined CPU core.
// Frames program bytes into imem words, runs the core, then streams readout bytes.
module prog_load_ctrl #(
    parameter int IMEM_DEPTH = 64,
    parameter int RUN_CYCLES = 200,
    parameter int DUMP_FIRST = 8,
    parameter int DUMP_COUNT = 16,
    localparam int AW = $clog2(IMEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    output logic          cpu_rst_o,
    output logic          dump_sel_o,
    output logic [4:0]    dump_addr_o,
    output logic [1:0]    dump_lane_o,
    input  logic [7:0]    value_i,
    output logic [7:0]    out_byte_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DSET = 3'd3;
    localparam logic [2:0] S_DOUT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam int RCW = $clog2(RUN_CYCLES + 1);
    localparam logic [RCW-1:0] RUN_LAST = RCW'(RUN_CYCLES - 1);
    localparam logic [4:0] ADDR_FIRST = 5'(DUMP_FIRST);
    localparam logic [4:0] ADDR_LAST = 5'(DUMP_FIRST + DUMP_COUNT - 1);

    logic [2:0]     state_q, state_d;
    logic [1:0]     bcnt_q, bcnt_d;
    logic [23:0]    part_q, part_d;
    logic [AW:0]    waddr_q, waddr_d;
    logic           we_q, we_d;
    logic [AW-1:0]  iaddr_q, iaddr_d;
    logic [31:0]    idata_q, idata_d;
    logic           cpu_rst_q, cpu_rst_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [4:0]     daddr_q, daddr_d;
    logic [1:0]     lane_q, lane_d;
    logic [7:0]     obyte_q, obyte_d;
    logic           ovalid_q, ovalid_d;
    logic           err_q, err_d;

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        part_d    = part_q;
        waddr_d   = waddr_q;
        we_d      = 1'b0;
        iaddr_d   = iaddr_q;
        idata_d   = idata_q;
        cpu_rst_d = cpu_rst_q;
        rcnt_d    = rcnt_q;
        daddr_d   = daddr_q;
        lane_d    = lane_q;
        obyte_d   = obyte_q;
        ovalid_d  = ovalid_q;
        err_d     = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (byte_valid_i && byte_i == 8'hFE) begin
                    state_d = S_LOAD;
                    bcnt_d  = 2'd0;
                    waddr_d = '0;
                end
            end
            S_LOAD: begin
                if (byte_valid_i) begin
                    if (bcnt_q == 2'd0 && byte_i == 8'hFF) begin
                        state_d   = S_RUN;
                        cpu_rst_d = 1'b0;
                        rcnt_d    = '0;
                    end else if (bcnt_q != 2'd3) begin
                        part_d = {part_q[15:0], byte_i};
                        bcnt_d = bcnt_q + 2'd1;
                    end else begin
                        bcnt_d = 2'd0;
                        // waddr_q[AW] set means the memory is already full
                        if (waddr_q[AW]) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            we_d    = 1'b1;
                            iaddr_d = waddr_q[AW-1:0];
                            idata_d = {part_q, byte_i};
                            waddr_d = waddr_q + 1'b1;
                        end
                    end
                end
            end
            S_RUN: begin
                if (rcnt_q == RUN_LAST) begin
                    state_d = S_DSET;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_DSET: begin
                obyte_d  = value_i;
                ovalid_d = 1'b1;
                state_d  = S_DOUT;
            end
            S_DOUT: begin
                if (out_ready_i) begin
                    ovalid_d = 1'b0;
                    if (lane_q != 2'd0) begin
                        lane_d  = lane_q - 2'd1;
                        state_d = S_DSET;
                    end else if (daddr_q == ADDR_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        lane_d  = 2'd3;
                        daddr_d = daddr_q + 5'd1;
                        state_d = S_DSET;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bcnt_q    <= 2'd0;
            part_q    <= '0;
            waddr_q   <= '0;
            we_q      <= 1'b0;
            iaddr_q   <= '0;
            idata_q   <= '0;
            cpu_rst_q <= 1'b1;
            rcnt_q    <= '0;
            daddr_q   <= ADDR_FIRST;
            lane_q    <= 2'd3;
            obyte_q   <= '0;
            ovalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            part_q    <= part_d;
            waddr_q   <= waddr_d;
            we_q      <= we_d;
            iaddr_q   <= iaddr_d;
            idata_q   <= idata_d;
            cpu_rst_q <= cpu_rst_d;
            rcnt_q    <= rcnt_d;
            daddr_q   <= daddr_d;
            lane_q    <= lane_d;
            obyte_q   <= obyte_d;
            ovalid_q  <= ovalid_d;
            err_q     <= err_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = iaddr_q;
    assign imem_wdata_o = idata_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign dump_sel_o   = 1'b1;
    assign dump_addr_o  = daddr_q;
    assign dump_lane_o  = lane_q;
    assign out_byte_o   = obyte_q;
    assign out_valid_o  = ovalid_q;
    assign done_o       = (state_q == S_DONE);
    assign err_o        = err_q;

endmodule
